// File: rtl/bram_port_ctrl_pkg.sv
// Shared types for the block-RAM load/store front-end.
package bram_port_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } bpc_state_t;

endpackage

// File: rtl/bram_port_ctrl_if.sv
// Request/response handshake bus between the CPU memory stage and the controller.
interface bram_port_ctrl_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWe;
  logic [1:0]  reqSize;
  logic        reqUnsigned;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic        rspErr;

  modport master (
    output reqValid, reqWe, reqSize, reqUnsigned, reqAddr, reqWData, rspReady,
    input  reqReady, rspValid, rspData, rspErr
  );

  modport slave (
    input  reqValid, reqWe, reqSize, reqUnsigned, reqAddr, reqWData, rspReady,
    output reqReady, rspValid, rspData, rspErr
  );
endinterface

// File: rtl/bram_port_ctrl_lane.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mem_lane_align
  import bram_port_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_off,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane and extend it to a full word for loads.
  always_comb begin
    w_byte = i_rdata[{i_off, 3'b000} +: 8];
    w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
    case (i_size)
      SZ_B:    o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_H:    o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_rdata;
    endcase
  end

  // Replace the addressed lane of the read word with the store data.
  always_comb begin
    o_merge = i_rdata;
    case (i_size)
      SZ_B:    o_merge[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata;
      default: o_merge = i_rdata;
    endcase
  end

endmodule

// File: rtl/bram_port_ctrl.sv
// Load/store front-end for a single-port word-wide BRAM with 1-cycle read latency.
module bram_port_ctrl
  import bram_port_ctrl_pkg::*;
#(
  parameter int unsigned P_DEPTH = 256,
  localparam int unsigned AW = $clog2(P_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  bram_port_ctrl_if.slave  bus,
  output logic             ramEn,
  output logic             ramWe,
  output logic [AW-1:0]    ramAddr,
  output logic [31:0]      ramWData,
  input  logic [31:0]      ramRData
);

  bpc_state_t    r_state;
  logic [1:0]    r_off;
  mem_size_t     r_size;
  logic          r_uns;
  logic          r_we;
  logic [15:0]   r_wdata;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_rspData;
  logic          r_rspErr;

  mem_size_t     w_size;
  logic          w_acc;
  logic          w_err;
  logic          w_sw;
  logic [31:0]   w_hi;
  logic [31:0]   w_load;
  logic [31:0]   w_merge;

  assign w_size       = mem_size_t'(bus.reqSize);
  assign bus.reqReady = (r_state == IDLE) & ~rst;
  assign w_acc        = bus.reqValid & bus.reqReady;
  assign w_sw         = bus.reqWe & (w_size == SZ_W);
  assign bus.rspValid = (r_state == RSP);
  assign bus.rspData  = r_rspData;
  assign bus.rspErr   = r_rspErr;

  // Classify the incoming request as illegal, misaligned or out of range.
  always_comb begin
    w_hi  = bus.reqAddr >> (AW + 2);
    w_err = (w_size == SZ_BAD)
          | ((w_size == SZ_H) & bus.reqAddr[0])
          | ((w_size == SZ_W) & (bus.reqAddr[1:0] != 2'b00))
          | (w_hi != '0);
  end

  mem_lane_align u_lane (
    .i_rdata    (ramRData),
    .i_wdata    (r_wdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // RAM pins: accept-cycle access straight from the request, RMW write-back from RD.
  // Because r_state resets asynchronously, an RMW write pending in RD is dropped on reset.
  always_comb begin
    ramEn    = 1'b0;
    ramWe    = 1'b0;
    ramAddr  = r_idx;
    ramWData = w_merge;
    if (w_acc && !w_err) begin
      ramEn    = 1'b1;
      ramWe    = w_sw;
      ramAddr  = bus.reqAddr[AW+1:2];
      ramWData = bus.reqWData;
    end else if ((r_state == RD) && r_we) begin
      ramEn = 1'b1;
      ramWe = 1'b1;
    end
  end

  // FSM, request latch and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_off     <= '0;
      r_size    <= SZ_B;
      r_uns     <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_idx     <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_off   <= bus.reqAddr[1:0];
            r_size  <= w_size;
            r_uns   <= bus.reqUnsigned;
            r_we    <= bus.reqWe;
            r_wdata <= bus.reqWData[15:0];
            r_idx   <= bus.reqAddr[AW+1:2];
            if (w_err || w_sw) begin
              r_rspErr  <= w_err;
              r_rspData <= '0;
              r_state   <= RSP;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: begin
          r_rspErr  <= 1'b0;
          r_rspData <= r_we ? '0 : w_load;
          r_state   <= RSP;
        end
        RSP: begin
          if (bus.rspReady) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
